// File: rtl/branch_pkg.sv
// Shared branch opcodes, BHT counter encodings and small helpers for the
// branch resolution / prediction unit.
package branch_pkg;

  localparam logic [4:0] BR_BEQ  = 5'd21;
  localparam logic [4:0] BR_BNE  = 5'd22;
  localparam logic [4:0] BR_BGTZ = 5'd23;
  localparam logic [4:0] BR_BGEZ = 5'd24;
  localparam logic [4:0] BR_BLTZ = 5'd25;
  localparam logic [4:0] BR_BLEZ = 5'd26;

  localparam logic [1:0] CTR_SNT   = 2'd0;
  localparam logic [1:0] CTR_WNT   = 2'd1;
  localparam logic [1:0] CTR_WT    = 2'd2;
  localparam logic [1:0] CTR_ST    = 2'd3;
  localparam logic [1:0] CTR_RESET = CTR_WNT;

  function automatic logic is_branch(input logic [4:0] alu_code);
    logic res;
    case (alu_code)
      BR_BEQ, BR_BNE, BR_BGTZ, BR_BGEZ, BR_BLTZ, BR_BLEZ: res = 1'b1;
      default:                                            res = 1'b0;
    endcase
    return res;
  endfunction

  // Two-bit saturating counter step: taken moves toward CTR_ST, not-taken toward CTR_SNT.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      if (ctr != CTR_ST) nxt = ctr + 2'd1;
      else               nxt = ctr;
    end else begin
      if (ctr != CTR_SNT) nxt = ctr - 2'd1;
      else                nxt = ctr;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluation; signed variants compare data1
// against zero as a two's-complement value.
module branch_cond_eval
  import branch_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [4:0]        alu_code,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  output logic              is_branch_s,
  output logic              taken_s
);

  logic d1_neg_s;
  logic d1_zero_s;

  assign d1_neg_s  = data1[DATA_W-1];
  assign d1_zero_s = (data1 == {DATA_W{1'b0}});

  // Decode opcode and resolve the branch condition.
  always_comb begin
    is_branch_s = is_branch(alu_code);
    taken_s     = 1'b0;
    case (alu_code)
      BR_BEQ:  taken_s = (data1 == data2);
      BR_BNE:  taken_s = (data1 != data2);
      BR_BGTZ: taken_s = ~d1_neg_s & ~d1_zero_s;
      BR_BGEZ: taken_s = ~d1_neg_s;
      BR_BLTZ: taken_s = d1_neg_s;
      BR_BLEZ: taken_s = d1_neg_s | d1_zero_s;
      default: taken_s = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_unit_bht.sv
// EX-stage branch resolution with a 2-bit-counter BHT read by fetch,
// registered mispredict redirect and saturating statistics.
module branch_unit_bht
  import branch_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int BHT_DEPTH = 64,
  parameter int STAT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] if_pc,
  output logic              if_pred_taken,
  input  logic              ex_valid,
  input  logic              ex_kill,
  input  logic [DATA_W-1:0] ex_pc,
  input  logic [4:0]        alu_code,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic [DATA_W-1:0] sign_extend,
  input  logic              ex_pred_taken,
  output logic              branch,
  output logic [DATA_W-1:0] branch_addr,
  output logic              redirect,
  output logic [DATA_W-1:0] redirect_pc,
  output logic [STAT_W-1:0] br_count,
  output logic [STAT_W-1:0] mispred_count
);

  localparam int                IDX_W    = $clog2(BHT_DEPTH);
  localparam logic [DATA_W-1:0] PC_STEP  = DATA_W'(32'd4);
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};
  localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

  logic [1:0]        bht_r [BHT_DEPTH];
  logic              branch_r;
  logic              redirect_r;
  logic [DATA_W-1:0] branch_addr_r;
  logic [DATA_W-1:0] redirect_pc_r;
  logic [STAT_W-1:0] br_count_r;
  logic [STAT_W-1:0] mispred_count_r;

  logic [IDX_W-1:0]  if_idx_s;
  logic [IDX_W-1:0]  ex_idx_s;
  logic              is_branch_s;
  logic              taken_s;
  logic              live_s;
  logic              bht_we_s;
  logic              mispred_s;
  logic [DATA_W-1:0] target_s;
  logic [DATA_W-1:0] seq_pc_s;
  logic              unused_pc_bits_s;

  branch_cond_eval #(.DATA_W(DATA_W)) u_cond (
    .alu_code    (alu_code),
    .data1       (data1),
    .data2       (data2),
    .is_branch_s (is_branch_s),
    .taken_s     (taken_s)
  );

  assign if_idx_s         = if_pc[IDX_W+1:2];
  assign ex_idx_s         = ex_pc[IDX_W+1:2];
  assign unused_pc_bits_s = ^{if_pc[DATA_W-1:IDX_W+2], if_pc[1:0]};

  // Fetch sees the registered table, so a same-cycle update is visible only next cycle.
  assign if_pred_taken = bht_r[if_idx_s][1];

  // Liveness, mispredict and target arithmetic for the EX instruction.
  always_comb begin
    live_s    = ex_valid & ~ex_kill;
    bht_we_s  = live_s & is_branch_s;
    mispred_s = live_s & (taken_s != ex_pred_taken);
    seq_pc_s  = ex_pc + PC_STEP;
    target_s  = seq_pc_s + (sign_extend << 2);
  end

  // BHT storage: reset to weak-NT, saturating update on live branches.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_r[i] <= CTR_RESET;
      end
    end else if (bht_we_s) begin
      bht_r[ex_idx_s] <= ctr_next(bht_r[ex_idx_s], taken_s);
    end
  end

  // Registered resolution results and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_r        <= 1'b0;
      redirect_r      <= 1'b0;
      branch_addr_r   <= {DATA_W{1'b0}};
      redirect_pc_r   <= {DATA_W{1'b0}};
      br_count_r      <= {STAT_W{1'b0}};
      mispred_count_r <= {STAT_W{1'b0}};
    end else begin
      branch_r   <= live_s & taken_s;
      redirect_r <= mispred_s;
      if (live_s) begin
        branch_addr_r <= target_s;
        redirect_pc_r <= taken_s ? target_s : seq_pc_s;
      end
      if (bht_we_s && (br_count_r != STAT_MAX)) begin
        br_count_r <= br_count_r + STAT_ONE;
      end
      if (mispred_s && (mispred_count_r != STAT_MAX)) begin
        mispred_count_r <= mispred_count_r + STAT_ONE;
      end
    end
  end

  assign branch        = branch_r;
  assign redirect      = redirect_r;
  assign branch_addr   = branch_addr_r;
  assign redirect_pc   = redirect_pc_r;
  assign br_count      = br_count_r;
  assign mispred_count = mispred_count_r;

endmodule

// File: doc/branch_unit_bht.md
# branch_unit_bht

Parametrised branch resolution and prediction unit. Replaces the combinational branch controller in the EX stage. Adds:
- A branch history table (BHT) of 2-bit saturating counters that the fetch stage reads to predict taken/not-taken.
- Signed compare variants.
- Registered mispredict redirect.
- Saturating statistics counters.

Fetch reads the prediction combinationally. EX resolves the branch and updates the table. The registered redirect steers the PC mux one cycle later.

## Interface
Parameters:
- DATA_W, 32, operand, PC and offset width
- BHT_DEPTH, 64, number of BHT entries; power of two, minimum 2
- STAT_W, 16, width of the statistics counters

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- if_pc  in  DATA_W  fetch PC used for the prediction lookup
- if_pred_taken  out  1  prediction: MSB of BHT[idx(if_pc)]; combinational
- ex_valid  in  1  EX holds a live instruction
- ex_kill  in  1  EX instruction is squashed; overrides ex_valid
- ex_pc  in  DATA_W  PC of the EX instruction
- alu_code  in  5  operation code
- data1, data2  in  DATA_W  register operands
- sign_extend  in  DATA_W  sign-extended word offset
- ex_pred_taken  in  1  prediction carried down the pipe with this instruction
- branch  out  1  registered; resolved branch was taken
- branch_addr  out  DATA_W  registered target: ex_pc + 4 + (sign_extend << 2), modulo 2^DATA_W
- redirect  out  1  registered; mispredict, fetch must load redirect_pc
- redirect_pc  out  DATA_W  registered correct next PC
- br_count, mispred_count  out  STAT_W  saturating statistics counters

## Operation
- idx(pc) = pc[log2(BHT_DEPTH)+1 : 2].
- A cycle is live when ex_valid && !ex_kill.
- Branch codes and conditions:
  - 21 beq: data1 == data2
  - 22 bne: data1 != data2
  - 23 bgtz: $signed(data1) > 0
  - 24 bgez: $signed(data1) >= 0
  - 25 bltz: $signed(data1) < 0
  - 26 blez: $signed(data1) <= 0
  - All other codes: not a branch, taken = 0.
- On a live branch:
  - Update BHT[idx(ex_pc)] by saturating counter: taken increments, saturating at 3; not-taken decrements, saturating at 0.
  - Increment br_count.
- Mispredict = live && (taken != ex_pred_taken). This also covers a non-branch that was predicted taken: redirect to ex_pc + 4.
- Redirect target:
  - taken: redirect_pc = branch target
  - not taken: redirect_pc = ex_pc + 4
- Mispredict increments mispred_count.
- Non-branch and non-live cycles leave the BHT unchanged.
- Counter states: 0 strong-NT, 1 weak-NT, 2 weak-T, 3 strong-T. Prediction is the counter MSB.
- Statistics counters hold at 2^STAT_W − 1 and never wrap.

## Timing
- Resolution latency is 1 cycle. branch, branch_addr, redirect and redirect_pc are registered from the EX inputs of the previous cycle.
- When the previous cycle was not live, branch = 0 and redirect = 0; branch_addr and redirect_pc hold their last values.
- redirect is a single-cycle pulse per mispredict. Back-to-back live mispredicts give consecutive pulses.
- Read/write collision: when if_pc and ex_pc map to the same index in the same cycle, if_pred_taken returns the pre-update value. The new value is visible next cycle.
- Reset, in the clock edge where rst = 1:
  - All BHT entries are set to 1 (weak-NT).
  - branch = redirect = 0, branch_addr = redirect_pc = 0, both counters = 0.
- rst overrides a simultaneous live EX instruction: no update, no redirect. It applies mid-operation as well.
- if_pred_taken reads 0 in the cycle after reset.

## Structure
- Package branch_pkg holds:
  - Codes BR_BEQ=21, BR_BNE=22, BR_BGTZ=23, BR_BGEZ=24, BR_BLTZ=25, BR_BLEZ=26.
  - Counter constants CTR_SNT=0, CTR_WNT=1, CTR_WT=2, CTR_ST=3, CTR_RESET=CTR_WNT.
  - Function is_branch(alu_code).
- Sub-module branch_cond_eval: combinational. Inputs alu_code, data1, data2; outputs is_branch and taken.
- Top level holds the BHT register array, target adder, output registers and statistics counters.

## Test plan
- Reset, then beq at ex_pc=0x100, data1=data2=5, sign_extend=3, ex_pred_taken=0. Next cycle requires branch=1, redirect=1, redirect_pc=branch_addr=0x110, br_count=1, mispred_count=1. BHT[0] is then 2 and if_pred_taken=1 for if_pc=0x100.
- bgtz at 0x200 with data1=0xFFFFFFFF (−1) and ex_pred_taken=0. Requires branch=0 (signed compare), redirect=0.
- Non-branch code 3 at 0x300 with ex_pred_taken=1. Requires redirect=1, redirect_pc=0x304, BHT unchanged, br_count unchanged.
- Four taken branches at 0x400 followed by four not-taken. Counter sequence must be 2,3,3,3,2,1,0,0; each not-taken with prediction matched produces no redirect.
- Same-cycle if_pc=ex_pc=0x500 with a taken update from counter 1. if_pred_taken=0 that cycle and 1 the next.
- Live mispredicting branch with rst=1 in the same cycle. Requires redirect=0 and all BHT entries=1. Also ex_kill=1 with a branch: no update, no redirect.
